uart_ctrl: RTL and testbench
============================

# uart_ctrl

Parametrised full-duplex UART for the Tang Nano 20K designs, replacing the fixed 8N1 change-detect UART. The transmitter takes bytes through a valid/ready handshake, so repeated identical bytes are sent. The receiver adds an input synchroniser, configurable parity, and framing/parity error reporting. It sits between board-level logic (buttons, LEDs, command decoders) and the `uartTx`/`uartRx` pins.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..8; sent LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2; the receiver checks only the first stop bit.
- `DIV_W`, 16: width of `baud_div`.

- `clk` in 1: system clock (27 MHz on board).
- `rst` in 1: asynchronous, active-high reset.
- `baud_div` in DIV_W: bit period = `baud_div`+1 clocks; must be ≥ 3; latched at frame start.
- `tx_data` in DATA_BITS: byte to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: transmitter idle. Reset 1.
- `TX` out 1: serial out, registered. Reset 1 (line idle).
- `RX` in 1: serial in, asynchronous to `clk`.
- `rx_data` out DATA_BITS: last received word; held until the next frame completes. Reset 0.
- `rx_valid` out 1: one-cycle pulse when a frame completes. Reset 0.
- `rx_frame_err` out 1: qualified by `rx_valid`; first stop bit sampled 0. Reset 0.
- `rx_parity_err` out 1: qualified by `rx_valid`; parity mismatch (always 0 when PARITY=0). Reset 0.
- `rx_busy` out 1: receiver not idle. Reset 0.

## Operation
- **TX FSM** (states IDLE, START, DATA, PAR, STOP):
  - IDLE: `tx_ready`=1, `TX`=1.
  - Accept on the rising edge where `tx_valid` && `tx_ready`. That edge latches `tx_data` and `baud_div`, computes parity, sets `TX`=0 and drops `tx_ready`.
  - Each state holds `TX` for `baud_div`+1 clocks.
  - PAR is skipped when PARITY=0. STOP lasts STOP_BITS bit periods.
  - Changes to `tx_data` while busy are ignored.
- **RX path**:
  - `RX` passes through a 2-flop synchroniser, reset to 1.
  - RX FSM states: IDLE, START, DATA, PAR, STOP, BREAK.
  - IDLE → START on synchronised `RX`=0; latches `baud_div`.
  - START samples at (`baud_div`>>1) clocks. If 1, return to IDLE (glitch, no `rx_valid`). Otherwise go to DATA.
  - DATA/PAR/STOP each sample once per `baud_div`+1 clocks, so sampling stays mid-bit.
  - At the STOP sample: update `rx_data`, pulse `rx_valid` with both error flags.
  - Stop sampled 0 → frame error, then BREAK: wait for `RX`=1 before IDLE.
  - A stop sampled 1 returns to IDLE immediately, so the next start edge is caught during the stop bit's second half.
- **Arithmetic**:
  - Odd parity bit = ~^data; even = ^data, over DATA_BITS bits only.
  - Bit counters are 4 bits wide; the baud counter is DIV_W bits and counts up to `baud_div`.
- **Reset mid-frame**: both FSMs go to IDLE at once, `TX`=1, no partial `rx_valid`.

## Timing
- `TX` falls in the cycle after acceptance.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × (`baud_div`+1) clocks.
- `tx_ready` rises in the cycle after the last stop period ends.
- Back-to-back frames: `tx_valid` held high gives exactly one idle clock of `TX`=1 between frames.
- `rx_valid` asserts 2 (sync) + 1 clocks after the stop mid-sample.
- TX and RX are fully independent; simultaneous activity is legal.

## Structure
- Package `uart_pkg` holds:
  - parity encoding constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - TX and RX state encodings;
  - a `uart_baud(clock, baud)` constant function returning clock/baud−1.
- One sub-module, `uart_bit_timer`. It loads a period, supports a half-period load, and emits a `tick`. It is instantiated once in TX and once in RX.

## Test plan
- 8N1, `baud_div`=233, send 0x41 → `TX` = 0,1,0,0,0,0,0,1,0,1, each held 234 clocks; `tx_ready` low for 2340 clocks.
- Send 0x41 twice with `tx_valid` held → two identical frames separated by 1 idle clock.
- PARITY=2, DATA_BITS=7, TX looped to RX, send 0x55 → `rx_valid` once, `rx_data`=0x55, parity bit 0, no errors. Repeat with PARITY=1 → parity bit 1.
- Inject a frame with a corrupted parity bit → `rx_parity_err`=1 with `rx_valid`. Stop bit forced 0 → `rx_frame_err`=1, receiver stays in BREAK until `RX`=1.
- `RX` low pulse of 50 clocks (`baud_div`=233) → no `rx_valid`, back to IDLE.
- Assert `rst` mid-DATA on both paths → `TX`=1, `tx_ready`=1 and `rx_valid`=0 immediately. The next frame transfers correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encodings and baud helper for uart_ctrl
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // Divider value for a given clock and baud rate (bit period = result + 1 clocks).
  function automatic int uart_baud(input int clock, input int baud);
    return clock / baud - 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter with full/half period load and tick output
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             half_i,
  input  logic [DIV_W-1:0] period_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] lim_q;
  logic [DIV_W-1:0] per_q;

  // Count up to the current limit; after a half-period the limit reverts to the full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      lim_q <= '0;
      per_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
      per_q <= period_i;
      lim_q <= half_i ? (period_i >> 1) : period_i;
    end else if (en_i) begin
      if (cnt_q == lim_q) begin
        cnt_q <= '0;
        lim_q <= per_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign tick_o = en_i && (cnt_q == lim_q);

endmodule

// File: rtl/uart_ctrl.sv
// rtl/uart_ctrl.sv - parametrised full-duplex UART with handshake TX and checked RX
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 TX,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_busy
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam bit         HAS_PAR   = (PARITY != PAR_NONE);

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == PAR_ODD) ? ~^d : ^d;
  endfunction

  tx_state_e tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;
  logic tx_q, tx_d, tx_par_q, tx_par_d;
  logic tx_accept, tx_tick;

  rx_state_e rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic rx_s1_q, rx_s2_q;
  logic rx_perr_q, rx_perr_d;
  logic rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d, rx_perr_out_q, rx_perr_out_d;
  logic rx_tick, rx_start;

  assign tx_accept = tx_valid && (tx_state_q == TX_IDLE);
  assign rx_start  = (rx_state_q == RX_IDLE) && !rx_s2_q;

  uart_bit_timer #(.DIV_W(DIV_W)) u_tx_timer (
    .clk(clk), .rst(rst), .en_i(tx_state_q != TX_IDLE), .load_i(tx_accept),
    .half_i(1'b0), .period_i(baud_div), .tick_o(tx_tick)
  );

  uart_bit_timer #(.DIV_W(DIV_W)) u_rx_timer (
    .clk(clk), .rst(rst), .en_i((rx_state_q != RX_IDLE) && (rx_state_q != RX_BREAK)),
    .load_i(rx_start), .half_i(1'b1), .period_i(baud_div), .tick_o(rx_tick)
  );

  // State and datapath registers for both directions; reset leaves the line idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q    <= TX_IDLE;
      tx_sh_q       <= '0;
      tx_cnt_q      <= '0;
      tx_q          <= 1'b1;
      tx_par_q      <= 1'b0;
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_state_q    <= RX_IDLE;
      rx_sh_q       <= '0;
      rx_cnt_q      <= '0;
      rx_perr_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_ferr_q     <= 1'b0;
      rx_perr_out_q <= 1'b0;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_sh_q       <= tx_sh_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_q          <= tx_d;
      tx_par_q      <= tx_par_d;
      rx_s1_q       <= RX;
      rx_s2_q       <= rx_s1_q;
      rx_state_q    <= rx_state_d;
      rx_sh_q       <= rx_sh_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_perr_q     <= rx_perr_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_ferr_q     <= rx_ferr_d;
      rx_perr_out_q <= rx_perr_out_d;
    end
  end

  // TX next state: the line value for the coming bit is decided at the tick that ends the current one.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    tx_cnt_d   = tx_cnt_q;
    tx_d       = tx_q;
    tx_par_d   = tx_par_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_accept) begin
          tx_state_d = TX_START;
          tx_sh_d    = tx_data;
          tx_par_d   = par_bit(tx_data);
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_state_d = TX_DATA;
          tx_d       = tx_sh_q[0];
          tx_sh_d    = tx_sh_q >> 1;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          if (tx_cnt_q == LAST_DATA) begin
            tx_cnt_d = '0;
            if (HAS_PAR) begin
              tx_state_d = TX_PAR;
              tx_d       = tx_par_q;
            end else begin
              tx_state_d = TX_STOP;
              tx_d       = 1'b1;
            end
          end else begin
            tx_cnt_d = tx_cnt_q + 4'd1;
            tx_d     = tx_sh_q[0];
            tx_sh_d  = tx_sh_q >> 1;
          end
        end
      end
      TX_PAR: begin
        if (tx_tick) begin
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          if (tx_cnt_q == LAST_STOP) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_cnt_d = tx_cnt_q + 4'd1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX next state: sample the synchronised line at each mid-bit tick.
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_sh_d       = rx_sh_q;
    rx_cnt_d      = rx_cnt_q;
    rx_perr_d     = rx_perr_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    rx_ferr_d     = rx_ferr_q;
    rx_perr_out_d = rx_perr_out_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_start) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
          rx_perr_d  = 1'b0;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
          if (rx_cnt_q == LAST_DATA) begin
            rx_cnt_d   = '0;
            rx_state_d = HAS_PAR ? RX_PAR : RX_STOP;
          end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
      end
      RX_PAR: begin
        if (rx_tick) begin
          rx_perr_d  = rx_s2_q ^ par_bit(rx_sh_q);
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_data_d     = rx_sh_q;
          rx_valid_d    = 1'b1;
          rx_ferr_d     = !rx_s2_q;
          rx_perr_out_d = rx_perr_q;
          rx_state_d    = rx_s2_q ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (rx_s2_q) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Outputs derived from state and registers.
  always_comb begin
    tx_ready      = (tx_state_q == TX_IDLE);
    rx_busy       = (rx_state_q != RX_IDLE);
    TX            = tx_q;
    rx_data       = rx_data_q;
    rx_valid      = rx_valid_q;
    rx_frame_err  = rx_ferr_q;
    rx_parity_err = rx_perr_out_q;
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// tb/tb_uart_ctrl.sv - directed self-checking bench for uart_ctrl
module tb_uart_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [15:0] baud0;
  logic [7:0]  txd0, rxd0;
  logic        txv0, rdy0, tx0, rx0, rv0, fe0, pe0, busy0;

  logic [15:0] baud_e;
  logic [6:0]  txd_e, rxd_e;
  logic        txv_e, rdy_e, tx_e, rx_e, rv_e, fe_e, pe_e, busy_e;
  logic        loop_e, rx_e_drv;

  logic [15:0] baud_o;
  logic [6:0]  txd_o, rxd_o;
  logic        txv_o, rdy_o, tx_o, rv_o, fe_o, pe_o, busy_o;

  assign rx_e = loop_e ? tx_e : rx_e_drv;

  uart_ctrl #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16)) u0 (
    .clk(clk), .rst(rst), .baud_div(baud0), .tx_data(txd0), .tx_valid(txv0),
    .tx_ready(rdy0), .TX(tx0), .RX(rx0), .rx_data(rxd0), .rx_valid(rv0),
    .rx_frame_err(fe0), .rx_parity_err(pe0), .rx_busy(busy0)
  );

  uart_ctrl #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .DIV_W(16)) u_e (
    .clk(clk), .rst(rst), .baud_div(baud_e), .tx_data(txd_e), .tx_valid(txv_e),
    .tx_ready(rdy_e), .TX(tx_e), .RX(rx_e), .rx_data(rxd_e), .rx_valid(rv_e),
    .rx_frame_err(fe_e), .rx_parity_err(pe_e), .rx_busy(busy_e)
  );

  uart_ctrl #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .DIV_W(16)) u_o (
    .clk(clk), .rst(rst), .baud_div(baud_o), .tx_data(txd_o), .tx_valid(txv_o),
    .tx_ready(rdy_o), .TX(tx_o), .RX(tx_o), .rx_data(rxd_o), .rx_valid(rv_o),
    .rx_frame_err(fe_o), .rx_parity_err(pe_o), .rx_busy(busy_o)
  );

  int compared = 0;
  int mismatched = 0;

  int rv_cnt0 = 0;
  int rv_cnt_e = 0;
  int rv_cnt_o = 0;
  logic fe_cap_e = 1'b0, pe_cap_e = 1'b0, fe_cap_o = 1'b0, pe_cap_o = 1'b0;

  // Count receive pulses and capture the flags they qualify.
  always @(posedge clk) begin
    if (rv0) rv_cnt0 <= rv_cnt0 + 1;
    if (rv_e) begin
      rv_cnt_e <= rv_cnt_e + 1;
      fe_cap_e <= fe_e;
      pe_cap_e <= pe_e;
    end
    if (rv_o) begin
      rv_cnt_o <= rv_cnt_o + 1;
      fe_cap_o <= fe_o;
      pe_cap_o <= pe_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [7:0] d);
    @(negedge clk);
    txd0 = d;
    txv0 = 1'b1;
    @(posedge clk);
    #1;
    txv0 = 1'b0;
  endtask

  task automatic send_e(input logic [6:0] d);
    @(negedge clk);
    txd_e = d;
    txv_e = 1'b1;
    @(posedge clk);
    #1;
    txv_e = 1'b0;
  endtask

  task automatic send_o(input logic [6:0] d);
    @(negedge clk);
    txd_o = d;
    txv_o = 1'b1;
    @(posedge clk);
    #1;
    txv_o = 1'b0;
  endtask

  // Drive a 10-bit frame (bit 0 first) onto the injected RX line, 16 clocks per bit.
  task automatic inj_e(input logic [9:0] bits);
    for (int i = 0; i < 10; i++) begin
      rx_e_drv = bits[i];
      repeat (16) @(posedge clk);
    end
    #1;
  endtask

  logic [9:0] frame41;
  logic [3:0] bi;
  logic [9:0] mid;
  int hold_err;
  int rdy_err;
  logic exp_bit;

  initial begin
    rst = 1'b1;
    baud0 = 16'd233; baud_e = 16'd15; baud_o = 16'd15;
    txd0 = '0; txv0 = 1'b0; rx0 = 1'b1;
    txd_e = '0; txv_e = 1'b0; loop_e = 1'b1; rx_e_drv = 1'b1;
    txd_o = '0; txv_o = 1'b0;
    frame41 = 10'b1010000010;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx0), 1);
    check("rst_tx_ready", 32'(rdy0), 1);
    check("rst_rx_data", 32'(rxd0), 0);
    check("rst_rx_valid", 32'(rv0), 0);
    check("rst_rx_flags", 32'({fe0, pe0, busy0}), 0);
    check("rst_e_o_outputs", 32'({tx_e, rdy_e, tx_o, rdy_o}), 32'hf);
    check("rst_e_o_rx", 32'({rxd_e, rxd_o, rv_e, rv_o, fe_e, pe_e, busy_e, fe_o, pe_o, busy_o}), 0);
    rst = 1'b0;
    wait_cyc(4);

    // 8N1 frame of 0x41, checked every cycle.
    send0(8'h41);
    hold_err = 0; rdy_err = 0;
    for (int c = 0; c < 2340; c++) begin
      bi = 4'(c / 234);
      if (tx0 !== frame41[bi]) hold_err++;
      if (rdy0 !== 1'b0) rdy_err++;
      if ((c % 234) == 117) mid[bi] = tx0;
      wait_cyc(1);
    end
    for (int k = 0; k < 10; k++) check($sformatf("t1_bit%0d", k), 32'(mid[k]), 32'(frame41[k]));
    check("t1_hold_errors", hold_err, 0);
    check("t1_ready_low_2340", rdy_err, 0);
    check("t1_ready_after", 32'(rdy0), 1);
    check("t1_tx_after", 32'(tx0), 1);

    // Back-to-back 0x41 with tx_valid held.
    @(negedge clk);
    txd0 = 8'h41;
    txv0 = 1'b1;
    @(posedge clk);
    #1;
    hold_err = 0;
    for (int c = 0; c < 4681; c++) begin
      if (c < 2340) begin
        bi = 4'(c / 234);
        exp_bit = frame41[bi];
      end else if (c == 2340) begin
        exp_bit = 1'b1;
        check("t2_idle_ready", 32'(rdy0), 1);
      end else begin
        bi = 4'((c - 2341) / 234);
        exp_bit = frame41[bi];
      end
      if (tx0 !== exp_bit) hold_err++;
      if (c == 2341) begin
        check("t2_second_accept", 32'(rdy0), 0);
        txv0 = 1'b0;
      end
      wait_cyc(1);
    end
    check("t2_two_frames", hold_err, 0);
    check("t2_ready_end", 32'(rdy0), 1);

    // 50-clock glitch on RX.
    rx0 = 1'b0;
    wait_cyc(30);
    check("glitch_busy", 32'(busy0), 1);
    wait_cyc(20);
    rx0 = 1'b1;
    wait_cyc(300);
    check("glitch_idle", 32'(busy0), 0);
    check("glitch_no_valid", rv_cnt0, 0);

    // 7E1 loopback of 0x55.
    send_e(7'h55);
    wait_cyc(136);
    check("even_par_bit", 32'(tx_e), 0);
    wait_cyc(250);
    check("even_rv_count", rv_cnt_e, 1);
    check("even_rx_data", 32'(rxd_e), 32'h55);
    check("even_errs", 32'({fe_cap_e, pe_cap_e}), 0);

    // 7O1 loopback of 0x55.
    send_o(7'h55);
    wait_cyc(136);
    check("odd_par_bit", 32'(tx_o), 1);
    wait_cyc(250);
    check("odd_rv_count", rv_cnt_o, 1);
    check("odd_rx_data", 32'(rxd_o), 32'h55);
    check("odd_errs", 32'({fe_cap_o, pe_cap_o}), 0);

    // Injected frame with wrong parity bit.
    loop_e = 1'b0;
    inj_e({1'b1, 1'b1, 7'h55, 1'b0});
    wait_cyc(20);
    check("perr_rv_count", rv_cnt_e, 2);
    check("perr_flag", 32'(pe_cap_e), 1);
    check("perr_no_ferr", 32'(fe_cap_e), 0);
    check("perr_data", 32'(rxd_e), 32'h55);

    // Injected frame with stop bit 0, line held low afterwards.
    inj_e({1'b0, 1'b0, 7'h33, 1'b0});
    wait_cyc(100);
    check("ferr_rv_count", rv_cnt_e, 3);
    check("ferr_flag", 32'(fe_cap_e), 1);
    check("ferr_no_perr", 32'(pe_cap_e), 0);
    check("ferr_data", 32'(rxd_e), 32'h33);
    check("ferr_break_busy", 32'(busy_e), 1);
    rx_e_drv = 1'b1;
    wait_cyc(5);
    check("ferr_break_exit", 32'(busy_e), 0);

    // Reset during DATA on both TX and RX.
    loop_e = 1'b1;
    send0(8'h41);
    wait_cyc(500);
    send_e(7'h55);
    wait_cyc(40);
    check("pre_rst_tx0_low", 32'(tx0), 0);
    check("pre_rst_txe_low", 32'(tx_e), 0);
    check("pre_rst_rx_busy", 32'(busy_e), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_tx0", 32'({tx0, rdy0}), 3);
    check("mid_rst_txe", 32'({tx_e, rdy_e}), 3);
    check("mid_rst_rx", 32'({rv_e, busy_e}), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(300);
    check("post_rst_no_valid", rv_cnt_e, 3);
    send_e(7'h2A);
    wait_cyc(136);
    check("post_rst_par_bit", 32'(tx_e), 1);
    wait_cyc(250);
    check("post_rst_rv_count", rv_cnt_e, 4);
    check("post_rst_data", 32'(rxd_e), 32'h2a);
    check("post_rst_errs", 32'({fe_cap_e, pe_cap_e}), 0);
    check("u0_never_valid", rv_cnt0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
